// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming 16/11 receive path.
// Covers the link-health state encoding and the FIFO entry layout.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    ALARM    = 2'd2
  } link_state_e;

  typedef struct packed {
    logic              corrected;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/hamming_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
// Push while full and pop while empty are ignored; the head reads as zero when empty.
module hamming_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] popData_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign doPush    = push_i && !full_o;
  assign doPop     = pop_i && !empty_o;
  assign popData_o = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (doPush && !doPop)      count_d = count_q + (PTR_W+1)'(1);
    else if (doPop && !doPush) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/hamming_rx_buffer_16_11.sv
// Receive buffer after the 16/11 Hamming decoder: drops uncorrectable words,
// queues good ones, keeps saturating error statistics and a sticky link alarm.
module hamming_rx_buffer_16_11
  import hamming_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter int ALARM_THRESH = 4
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [DATA_W-1:0] i_DecodWord,
  input  logic              i_ErrorC,
  input  logic              i_ErrorD,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Corrected,
  output logic [CNT_W-1:0]  o_CntCorr,
  output logic [CNT_W-1:0]  o_CntDet,
  output logic              o_Alarm,
  input  logic              i_Clear
);

  localparam logic [7:0] THRESH = 8'(ALARM_THRESH);

  link_state_e      state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [7:0]       runInc;
  logic [CNT_W-1:0] cntCorr_q, cntCorr_d;
  logic [CNT_W-1:0] cntDet_q, cntDet_d;

  logic        accept;
  logic        accDet;
  logic        accClean;
  logic        fifoPush;
  logic        fifoPop;
  logic        fifoFull;
  logic        fifoEmpty;
  fifo_entry_t pushEntry;
  fifo_entry_t headEntry;

  assign accept    = i_Valid && o_Ready;
  assign accDet    = accept && i_ErrorD;
  assign accClean  = accept && !i_ErrorD;
  assign fifoPush  = accClean && (state_q != ALARM);
  assign fifoPop   = o_Valid && i_Ready;
  assign pushEntry = '{corrected: i_ErrorC, data: i_DecodWord};
  assign runInc    = (run_q >= THRESH) ? run_q : run_q + 8'd1;

  hamming_sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fifo_entry_t))
  ) u_fifo (
    .clk_i      (i_Clk),
    .reset_i    (i_Reset),
    .push_i     (fifoPush),
    .pushData_i (pushEntry),
    .pop_i      (fifoPop),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .popData_o  (headEntry)
  );

  assign o_Ready     = !fifoFull;
  assign o_Valid     = !fifoEmpty;
  assign o_Data      = headEntry.data;
  assign o_Corrected = headEntry.corrected;
  assign o_CntCorr   = cntCorr_q;
  assign o_CntDet    = cntDet_q;
  assign o_Alarm     = (state_q == ALARM);

  // A word flagged both corrected and detected counts only as detected.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    cntCorr_d = cntCorr_q;
    cntDet_d  = cntDet_q;
    if (i_Clear) begin
      state_d   = NORMAL;
      run_d     = '0;
      cntCorr_d = '0;
      cntDet_d  = '0;
    end else if (accDet) begin
      if (cntDet_q != '1) cntDet_d = cntDet_q + CNT_W'(1);
      run_d = runInc;
      if (runInc >= THRESH)      state_d = ALARM;
      else if (state_q == NORMAL) state_d = DEGRADED;
    end else if (accClean) begin
      if (i_ErrorC && (cntCorr_q != '1)) cntCorr_d = cntCorr_q + CNT_W'(1);
      if (state_q != ALARM) begin
        run_d   = '0;
        state_d = NORMAL;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= NORMAL;
      run_q     <= '0;
      cntCorr_q <= '0;
      cntDet_q  <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cntCorr_q <= cntCorr_d;
      cntDet_q  <= cntDet_d;
    end
  end

endmodule
